// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared types and default widths for the 5-stage MIPS pipeline registers.
//   ctrl_t      : decode control bundle carried from ID down the pipe
//   CTRL_NOP    : all-zero control word, used for bubbles and flushed slots
//   DEF_DATA_W  : default datapath / immediate / PC width
//   DEF_REG_AW  : default register address width
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard equation. A hazard exists when EX
// holds a valid load whose destination (rt, non-zero) is read by the valid
// instruction currently in ID. Kept separate so the forwarding unit can
// reuse the same comparison.
// Ports:
//   i_ex_valid, i_ex_mem_read, i_ex_rt_addr : instruction sitting in EX
//   i_id_valid, i_id_uses_rs/rt, i_id_rs/rt_addr : instruction sitting in ID
//   o_hazard : 1 when the ID instruction must wait one cycle
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt_addr,
  input  logic              i_id_valid,
  input  logic              i_id_uses_rs,
  input  logic [REG_AW-1:0] i_id_rs_addr,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_rt_addr,
  output logic              o_hazard
);

  logic w_ex_is_load;
  logic w_rs_match;
  logic w_rt_match;

  // $0 is hard-wired to zero, so a load targeting it never produces a value
  // anyone has to wait for.
  assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rt_addr != '0);
  assign w_rs_match   = i_id_uses_rs & (i_id_rs_addr == i_ex_rt_addr);
  assign w_rt_match   = i_id_uses_rt & (i_id_rt_addr == i_ex_rt_addr);
  assign o_hazard     = w_ex_is_load & i_id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with load-use hazard detection. Captures decode
// outputs each cycle and presents them to EX one cycle later. Flush kills
// the instruction entering EX, stall freezes EX, and a load-use hazard
// inserts a one-cycle bubble while IF/ID holds via load_use_stall__o.
// Ports:
//   clock__i, reset__i (async, active-high)
//   id_* inputs    : decode-stage instruction fields and control bundle
//   stall__i       : freeze EX contents
//   flush__i       : zero the slot entering EX (wins over stall)
//   load_use_stall__o : combinational hold request to IF/ID
//   ex_* outputs   : registered copies; ex_ctrl__o is zero when not valid
//   bubble_cnt__o, flush_cnt__o : saturating event counters, present only
//                                 when ID_EX_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module id_ex_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clock__i,
  input  logic              reset__i,
  input  logic              id_valid__i,
  input  logic [DATA_W-1:0] id_pc4__i,
  input  logic [DATA_W-1:0] id_rs_data__i,
  input  logic [DATA_W-1:0] id_rt_data__i,
  input  logic [DATA_W-1:0] id_imm_ext__i,
  input  logic [REG_AW-1:0] id_rs_addr__i,
  input  logic [REG_AW-1:0] id_rt_addr__i,
  input  logic [REG_AW-1:0] id_rd_addr__i,
  input  logic              id_uses_rs__i,
  input  logic              id_uses_rt__i,
  input  ctrl_t             id_ctrl__i,
  input  logic              stall__i,
  input  logic              flush__i,
  output logic              load_use_stall__o,
  output logic              ex_valid__o,
  output logic [DATA_W-1:0] ex_pc4__o,
  output logic [DATA_W-1:0] ex_rs_data__o,
  output logic [DATA_W-1:0] ex_rt_data__o,
  output logic [DATA_W-1:0] ex_imm_ext__o,
  output logic [REG_AW-1:0] ex_rs_addr__o,
  output logic [REG_AW-1:0] ex_rt_addr__o,
  output logic [REG_AW-1:0] ex_rd_addr__o,
  output ctrl_t             ex_ctrl__o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt__o,
  output logic [31:0]       flush_cnt__o
`endif
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm_ext;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_rd_addr;
  ctrl_t             r_ctrl;

  logic w_hazard;
  logic w_load_use;
  logic w_clear;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rt_addr  (r_rt_addr),
    .i_id_valid    (id_valid__i),
    .i_id_uses_rs  (id_uses_rs__i),
    .i_id_rs_addr  (id_rs_addr__i),
    .i_id_uses_rt  (id_uses_rt__i),
    .i_id_rt_addr  (id_rt_addr__i),
    .o_hazard      (w_hazard)
  );

  // While EX is frozen the caller already holds ID, so a hazard request
  // would be redundant; it is suppressed to keep IF/ID control simple.
  assign w_load_use        = w_hazard & ~stall__i;
  assign load_use_stall__o = w_load_use;

  // Flush beats stall; a load-use bubble only applies when EX may advance.
  // w_load_use already excludes stall, so both cases collapse to one clear.
  assign w_clear = flush__i | w_load_use;

  always_ff @(posedge clock__i or posedge reset__i) begin
    if (reset__i) begin
      r_valid   <= 1'b0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm_ext <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_ctrl    <= CTRL_NOP;
    end else if (w_clear) begin
      r_valid   <= 1'b0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm_ext <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
      r_ctrl    <= CTRL_NOP;
    end else if (!stall__i) begin
      // Data fields are captured even for an invalid slot; only the control
      // word is masked so nothing downstream acts on it.
      r_valid   <= id_valid__i;
      r_pc4     <= id_pc4__i;
      r_rs_data <= id_rs_data__i;
      r_rt_data <= id_rt_data__i;
      r_imm_ext <= id_imm_ext__i;
      r_rs_addr <= id_rs_addr__i;
      r_rt_addr <= id_rt_addr__i;
      r_rd_addr <= id_rd_addr__i;
      r_ctrl    <= id_valid__i ? id_ctrl__i : CTRL_NOP;
    end
  end

  assign ex_valid__o   = r_valid;
  assign ex_pc4__o     = r_pc4;
  assign ex_rs_data__o = r_rs_data;
  assign ex_rt_data__o = r_rt_data;
  assign ex_imm_ext__o = r_imm_ext;
  assign ex_rs_addr__o = r_rs_addr;
  assign ex_rt_addr__o = r_rt_addr;
  assign ex_rd_addr__o = r_rd_addr;
  assign ex_ctrl__o    = r_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_bubble_evt;

  // A flush masking a hazard is counted as a flush only.
  assign w_bubble_evt = w_load_use & ~flush__i;

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clock__i or posedge reset__i) begin
    if (reset__i) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (flush__i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
      if (w_bubble_evt && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt__o = r_bubble_cnt;
  assign flush_cnt__o  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Self-checking bench for id_ex_stage_reg. A table of instruction vectors
// is applied one per cycle; each carries the expected hazard output and the
// expected EX action, from which the expected EX contents are queued and
// compared one edge later. Hand-written sequences cover reset behaviour.
// Counter ports are checked when ID_EX_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;
  import mips_pipe_pkg::*;

  typedef enum logic [1:0] {ACT_CAP, ACT_HOLD, ACT_ZERO} act_e;

  typedef struct {
    logic        valid;
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        usesRs;
    logic        usesRt;
    logic        stall;
    logic        flush;
    logic [31:0] imm;
    logic [31:0] rsData;
    logic        expLus;
    act_e        act;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  rdAddr;
    ctrl_t       ctrl;
  } exState_t;

  // reg_write, mem_read, mem_to_reg, alu_src set; alu_op = add
  localparam ctrl_t C_LW  = 11'b110_1100_0000;
  // reg_write, reg_dst set; alu_op = 2 (R-type)
  localparam ctrl_t C_ADD = 11'b100_0010_0010;

  logic        clock;
  logic        reset;
  logic        idValid;
  logic [31:0] idPc4;
  logic [31:0] idRsData;
  logic [31:0] idRtData;
  logic [31:0] idImm;
  logic [4:0]  idRsAddr;
  logic [4:0]  idRtAddr;
  logic [4:0]  idRdAddr;
  logic        idUsesRs;
  logic        idUsesRt;
  ctrl_t       idCtrl;
  logic        stall;
  logic        flush;
  logic        loadUseStall;
  logic        exValid;
  logic [31:0] exPc4;
  logic [31:0] exRsData;
  logic [31:0] exRtData;
  logic [31:0] exImm;
  logic [4:0]  exRsAddr;
  logic [4:0]  exRtAddr;
  logic [4:0]  exRdAddr;
  ctrl_t       exCtrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubbleCnt;
  logic [31:0] flushCnt;
`endif

  int       testsRun  = 0;
  int       failCount = 0;
  exState_t model;
  exState_t sbQueue[$];
  int       expBubbles = 0;
  int       expFlushes = 0;
  vec_t     vecs[$];

  id_ex_stage_reg dut (
    .clock__i          (clock),
    .reset__i          (reset),
    .id_valid__i       (idValid),
    .id_pc4__i         (idPc4),
    .id_rs_data__i     (idRsData),
    .id_rt_data__i     (idRtData),
    .id_imm_ext__i     (idImm),
    .id_rs_addr__i     (idRsAddr),
    .id_rt_addr__i     (idRtAddr),
    .id_rd_addr__i     (idRdAddr),
    .id_uses_rs__i     (idUsesRs),
    .id_uses_rt__i     (idUsesRt),
    .id_ctrl__i        (idCtrl),
    .stall__i          (stall),
    .flush__i          (flush),
    .load_use_stall__o (loadUseStall),
    .ex_valid__o       (exValid),
    .ex_pc4__o         (exPc4),
    .ex_rs_data__o     (exRsData),
    .ex_rt_data__o     (exRtData),
    .ex_imm_ext__o     (exImm),
    .ex_rs_addr__o     (exRsAddr),
    .ex_rt_addr__o     (exRtAddr),
    .ex_rd_addr__o     (exRdAddr),
    .ex_ctrl__o        (exCtrl)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt__o     (bubbleCnt),
    .flush_cnt__o      (flushCnt)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: counts it and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compares every EX output against one expected EX state.
  task automatic checkEx(input string tag, input exState_t e);
    checkOutput({tag, ".valid"},  32'(exValid),  32'(e.valid));
    checkOutput({tag, ".pc4"},    exPc4,         e.pc4);
    checkOutput({tag, ".rsData"}, exRsData,      e.rsData);
    checkOutput({tag, ".rtData"}, exRtData,      e.rtData);
    checkOutput({tag, ".imm"},    exImm,         e.imm);
    checkOutput({tag, ".rsAddr"}, 32'(exRsAddr), 32'(e.rsAddr));
    checkOutput({tag, ".rtAddr"}, 32'(exRtAddr), 32'(e.rtAddr));
    checkOutput({tag, ".rdAddr"}, 32'(exRdAddr), 32'(e.rdAddr));
    checkOutput({tag, ".ctrl"},   32'(exCtrl),   32'(e.ctrl));
  endtask

  task automatic checkCounters(input string tag);
`ifdef ID_EX_PERF_CNT_EN
    checkOutput({tag, ".bubbleCnt"}, bubbleCnt, 32'(expBubbles));
    checkOutput({tag, ".flushCnt"},  flushCnt,  32'(expFlushes));
`else
    if (tag.len() == 0) $display("[TB] empty counter tag");
`endif
  endtask

  function automatic vec_t mkVec(input logic valid, input ctrl_t ctrl,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic usesRs,
                                 input logic usesRt, input logic stallIn,
                                 input logic flushIn, input logic [31:0] imm,
                                 input logic [31:0] rsData,
                                 input logic expLus, input act_e act);
    vec_t v;
    v.valid  = valid;   v.ctrl   = ctrl;
    v.rs     = rs;      v.rt     = rt;      v.rd = rd;
    v.usesRs = usesRs;  v.usesRt = usesRt;
    v.stall  = stallIn; v.flush  = flushIn;
    v.imm    = imm;     v.rsData = rsData;
    v.expLus = expLus;  v.act    = act;
    return v;
  endfunction

  // Drives one vector at the falling edge, checks the combinational hazard
  // output before the rising edge, queues the expected EX state, and checks
  // the DUT against the oldest queued state just after the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    exState_t got;
    @(negedge clock);
    idValid  = v.valid;
    idCtrl   = v.ctrl;
    idRsAddr = v.rs;
    idRtAddr = v.rt;
    idRdAddr = v.rd;
    idUsesRs = v.usesRs;
    idUsesRt = v.usesRt;
    stall    = v.stall;
    flush    = v.flush;
    idImm    = v.imm;
    idRsData = v.rsData;
    idPc4    = 32'h0040_0000 + 32'(idx * 4);
    idRtData = $urandom;
    #1;
    checkOutput($sformatf("lus[%0d]", idx), 32'(loadUseStall), 32'(v.expLus));
    case (v.act)
      ACT_CAP: begin
        model.valid  = v.valid;
        model.pc4    = idPc4;
        model.rsData = v.rsData;
        model.rtData = idRtData;
        model.imm    = v.imm;
        model.rsAddr = v.rs;
        model.rtAddr = v.rt;
        model.rdAddr = v.rd;
        model.ctrl   = v.valid ? v.ctrl : CTRL_NOP;
      end
      ACT_ZERO: model = '0;
      default: ;
    endcase
    if (v.flush) expFlushes++;
    else if (v.expLus) expBubbles++;
    sbQueue.push_back(model);
    @(posedge clock);
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput($sformatf("sbEmpty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      got = sbQueue.pop_front();
      checkEx($sformatf("ex[%0d]", idx), got);
      checkCounters($sformatf("cnt[%0d]", idx));
    end
  endtask

  initial begin
    // Vectors: valid, ctrl, rs, rt, rd, usesRs, usesRt, stall, flush,
    //          imm, rsData, expected load_use_stall, expected EX action
    vecs.push_back(mkVec(1, C_ADD, 1, 2, 3,   1, 1, 0, 0, 32'hFFFF_FFF0, 32'h0000_1234, 0, ACT_CAP));  // 0 plain capture
    vecs.push_back(mkVec(1, C_LW,  1, 5, 0,   1, 0, 0, 0, 32'h0000_0010, 32'h0000_1000, 0, ACT_CAP));  // 1 lw rt=5
    vecs.push_back(mkVec(1, C_ADD, 5, 6, 7,   1, 1, 0, 0, 32'h0000_0000, 32'hAAAA_0001, 1, ACT_ZERO)); // 2 add rs=5: bubble
    vecs.push_back(mkVec(1, C_ADD, 5, 6, 7,   1, 1, 0, 0, 32'h0000_0000, 32'hAAAA_0002, 0, ACT_CAP));  // 3 retry
    vecs.push_back(mkVec(1, C_LW,  0, 0, 0,   1, 0, 0, 0, 32'h0000_0004, 32'h0000_2000, 0, ACT_CAP));  // 4 lw rt=0
    vecs.push_back(mkVec(1, C_ADD, 0, 4, 8,   1, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, ACT_CAP));  // 5 reads $0
    vecs.push_back(mkVec(1, C_LW,  2, 7, 0,   1, 0, 0, 0, 32'h0000_0008, 32'h0000_3000, 0, ACT_CAP));  // 6 lw rt=7
    vecs.push_back(mkVec(1, C_LW,  7, 8, 0,   1, 0, 0, 0, 32'h0000_000C, 32'h0000_3004, 1, ACT_ZERO)); // 7 dep lw
    vecs.push_back(mkVec(1, C_LW,  7, 8, 0,   1, 0, 0, 0, 32'h0000_000C, 32'h0000_3008, 0, ACT_CAP));  // 8 retry
    vecs.push_back(mkVec(1, C_ADD, 1, 8, 9,   1, 1, 0, 0, 32'h0000_0000, 32'h0000_0055, 1, ACT_ZERO)); // 9 rt=8 hazard
    vecs.push_back(mkVec(1, C_ADD, 1, 8, 9,   1, 1, 0, 0, 32'h0000_0000, 32'h0000_0056, 0, ACT_CAP));  // 10 retry
    vecs.push_back(mkVec(1, C_LW,  1, 9, 0,   1, 0, 0, 0, 32'h0000_0020, 32'h0000_4000, 0, ACT_CAP));  // 11 lw rt=9
    vecs.push_back(mkVec(1, C_ADD, 9, 3, 10,  1, 1, 1, 0, 32'h1111_1111, 32'hBEEF_0001, 0, ACT_HOLD)); // 12 stall
    vecs.push_back(mkVec(1, C_ADD, 9, 4, 11,  1, 1, 1, 0, 32'h2222_2222, 32'hBEEF_0002, 0, ACT_HOLD)); // 13 stall
    vecs.push_back(mkVec(1, C_ADD, 9, 5, 12,  1, 1, 1, 0, 32'h3333_3333, 32'hBEEF_0003, 0, ACT_HOLD)); // 14 stall
    vecs.push_back(mkVec(1, C_ADD, 9, 5, 12,  1, 1, 0, 0, 32'h0000_0000, 32'hBEEF_0004, 1, ACT_ZERO)); // 15 hazard now
    vecs.push_back(mkVec(1, C_ADD, 9, 5, 12,  1, 1, 0, 0, 32'h0000_0000, 32'hBEEF_0005, 0, ACT_CAP));  // 16 retry
    vecs.push_back(mkVec(1, C_LW,  2, 10, 0,  1, 0, 0, 0, 32'h0000_0030, 32'h0000_5000, 0, ACT_CAP));  // 17 lw rt=10
    vecs.push_back(mkVec(1, C_ADD, 10, 1, 2,  1, 1, 1, 1, 32'h0000_0000, 32'hCAFE_0001, 0, ACT_ZERO)); // 18 flush+stall+hazard
    vecs.push_back(mkVec(0, C_ADD, 10, 1, 2,  1, 1, 0, 0, 32'h0000_7777, 32'hCAFE_0002, 0, ACT_CAP));  // 19 invalid slot
    vecs.push_back(mkVec(1, C_ADD, 3, 4, 5,   1, 1, 0, 1, 32'h0000_0001, 32'hCAFE_0003, 0, ACT_ZERO)); // 20 flush alone
    vecs.push_back(mkVec(1, C_LW,  3, 11, 0,  1, 0, 0, 0, 32'h0000_0040, 32'h0000_6000, 0, ACT_CAP));  // 21 lw rt=11
    vecs.push_back(mkVec(1, C_ADD, 11, 1, 4,  1, 1, 0, 1, 32'h0000_0000, 32'hCAFE_0004, 1, ACT_ZERO)); // 22 flush masks hazard
    vecs.push_back(mkVec(1, C_ADD, 11, 1, 4,  1, 1, 0, 0, 32'h0000_0000, 32'hCAFE_0005, 0, ACT_CAP));  // 23 retry
    vecs.push_back(mkVec(1, C_LW,  3, 12, 0,  1, 0, 0, 0, 32'h0000_0050, 32'h0000_7000, 0, ACT_CAP));  // 24 lw rt=12
    vecs.push_back(mkVec(1, C_ADD, 12, 12, 6, 0, 0, 0, 0, 32'h0000_0000, 32'hCAFE_0006, 0, ACT_CAP));  // 25 unused match

    idValid = 0; idCtrl = CTRL_NOP; idRsAddr = 0; idRtAddr = 0; idRdAddr = 0;
    idUsesRs = 0; idUsesRt = 0; idImm = 0; idRsData = 0; idRtData = 0;
    idPc4 = 0; stall = 0; flush = 0;
    model = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkEx("reset", model);
    checkOutput("reset.lus", 32'(loadUseStall), 32'd0);
    checkCounters("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset mid-operation: EX holds a valid instruction and a stall is
    // pending; asserting reset must clear outputs before any clock edge.
    @(negedge clock);
    stall = 1'b1;
    #1;
    checkOutput("preReset.valid", 32'(exValid), 32'(model.valid));
    reset = 1'b1;
    #1;
    model      = '0;
    expBubbles = 0;
    expFlushes = 0;
    checkEx("midReset", model);
    checkOutput("midReset.lus", 32'(loadUseStall), 32'd0);
    checkCounters("midReset");
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    applyStimulus(99, mkVec(1, C_LW, 4, 13, 0, 1, 0, 0, 0, 32'h8000_0000,
                            32'h0000_9999, 0, ACT_CAP));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
